// File: rtl/instr_decode_issue_if.sv
// Fetch/issue/writeback handshake bundle for instr_decode_issue.
// master drives fetch, consumer-ready, writeback and flush; slave is the stage.
interface instr_decode_issue_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              if_valid;
   logic              if_ready;
   logic [DATA_W-1:0] if_instr;
   logic [DATA_W-1:0] if_pc;
   logic              id_valid;
   logic              id_ready;
   logic [5:0]        id_opc;
   logic [REG_AW-1:0] id_rd;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [DATA_W-1:0] id_imm;
   logic              id_use_imm;
   logic              id_we;
   logic [DATA_W-1:0] id_pc;
   logic              id_illegal;
   logic              wb_valid;
   logic [REG_AW-1:0] wb_rd;
   logic              flush;

   modport master (
      output if_valid, if_instr, if_pc,
      output id_ready, wb_valid, wb_rd, flush,
      input  if_ready, id_valid, id_opc,
      input  id_rd, id_rs1, id_rs2, id_imm,
      input  id_use_imm, id_we, id_pc, id_illegal
   );

   modport slave (
      input  if_valid, if_instr, if_pc,
      input  id_ready, wb_valid, wb_rd, flush,
      output if_ready, id_valid, id_opc,
      output id_rd, id_rs1, id_rs2, id_imm,
      output id_use_imm, id_we, id_pc, id_illegal
   );
endinterface

// File: rtl/instr_decode_issue.sv
// Decode/issue stage: field split, operand select, scoreboard stall, 1-entry output reg.
// Optional WB_BYPASS_EN: hazard check ignores the register retiring this cycle.
module instr_decode_issue #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int NUM_REGS = 32
) (
   input logic           clk,
   input logic           rst_n,
   instr_decode_issue_if.slave bus
);

   localparam logic [5:0] OP_ADD   = 6'h01;
   localparam logic [5:0] OP_SUB   = 6'h02;
   localparam logic [5:0] OP_STORE = 6'h03;
   localparam logic [5:0] OP_LOAD  = 6'h04;
   localparam logic [5:0] OP_MOVE  = 6'h05;
   localparam logic [5:0] OP_SGE   = 6'h06;
   localparam logic [5:0] OP_XOR   = 6'h0E;
   localparam logic [5:0] OP_NOT   = 6'h0F;
   localparam logic [5:0] OP_MOVEI = 6'h10;
   localparam logic [5:0] OP_SLI   = 6'h11;
   localparam logic [5:0] OP_SRI   = 6'h12;
   localparam logic [5:0] OP_ADDI  = 6'h13;
   localparam logic [5:0] OP_SUBI  = 6'h14;
   localparam logic [5:0] OP_JUMP  = 6'h15;
   localparam logic [5:0] OP_BRA   = 6'h16;

   typedef struct packed {
      logic              valid;
      logic [5:0]        opc;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [DATA_W-1:0] imm;
      logic              use_imm;
      logic              we;
      logic              illegal;
      logic [DATA_W-1:0] pc;
   } bundle_t;

   bundle_t             q;
   bundle_t             d;
   logic [NUM_REGS-1:0] sb;
   logic [NUM_REGS-1:0] sb_n;
   logic [NUM_REGS-1:0] sb_chk;

   logic [5:0]        opc;
   logic [REG_AW-1:0] f_rd;
   logic [REG_AW-1:0] f_rs1;
   logic [REG_AW-1:0] f_rs2;
   logic [DATA_W-1:0] imm_s16;
   logic [DATA_W-1:0] imm_s26;
   logic [DATA_W-1:0] imm_z5;

   logic c_rr, c_r1, c_movei, c_ri;
   logic c_sh, c_st, c_bra, c_jmp;
   logic use1, use2, we, use_imm;
   logic [DATA_W-1:0] imm;
   logic hazard;
   logic ready;
   logic accept;

   assign opc     = bus.if_instr[31:26];
   assign f_rd    = bus.if_instr[25:21];
   assign f_rs1   = bus.if_instr[20:16];
   assign f_rs2   = bus.if_instr[15:11];
   assign imm_s16 = {{(DATA_W-16){bus.if_instr[15]}},
                     bus.if_instr[15:0]};
   assign imm_s26 = {{(DATA_W-26){bus.if_instr[25]}},
                     bus.if_instr[25:0]};
   assign imm_z5  = {{(DATA_W-5){1'b0}},
                     bus.if_instr[4:0]};

   // Opcode classes share one operand/immediate shape each.
   always_comb begin
      c_rr    = (opc == OP_ADD) || (opc == OP_SUB) ||
                ((opc >= OP_SGE) && (opc <= OP_XOR));
      c_r1    = (opc == OP_MOVE) || (opc == OP_NOT);
      c_movei = (opc == OP_MOVEI);
      c_ri    = (opc == OP_ADDI) || (opc == OP_SUBI) ||
                (opc == OP_LOAD);
      c_sh    = (opc == OP_SLI) || (opc == OP_SRI);
      c_st    = (opc == OP_STORE);
      c_bra   = (opc == OP_BRA);
      c_jmp   = (opc == OP_JUMP);
   end

   always_comb begin
      use1    = 1'b0;
      use2    = 1'b0;
      we      = 1'b0;
      use_imm = 1'b0;
      imm     = '0;
      unique case (1'b1)
         c_rr: begin
            use1 = 1'b1;
            use2 = 1'b1;
            we   = 1'b1;
         end
         c_r1: begin
            use1 = 1'b1;
            we   = 1'b1;
         end
         c_movei: begin
            we      = 1'b1;
            use_imm = 1'b1;
            imm     = imm_s16;
         end
         c_ri: begin
            use1    = 1'b1;
            we      = 1'b1;
            use_imm = 1'b1;
            imm     = imm_s16;
         end
         c_sh: begin
            use1    = 1'b1;
            we      = 1'b1;
            use_imm = 1'b1;
            imm     = imm_z5;
         end
         c_st: begin
            use1    = 1'b1;
            use2    = 1'b1;
            use_imm = 1'b1;
            imm     = imm_s16;
         end
         c_bra: begin
            use1    = 1'b1;
            use_imm = 1'b1;
            imm     = imm_s16;
         end
         c_jmp: begin
            use_imm = 1'b1;
            imm     = imm_s26;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      d         = '0;
      d.valid   = 1'b1;
      d.opc     = opc;
      d.rd      = we   ? f_rd  : '0;
      d.rs1     = use1 ? f_rs1 : '0;
      d.rs2     = use2 ? f_rs2 : '0;
      d.imm     = imm;
      d.use_imm = use_imm;
      d.we      = we;
      d.illegal = (opc > OP_BRA);
      d.pc      = bus.if_pc;
   end

   always_comb begin
      sb_chk = sb;
`ifdef WB_BYPASS_EN
      if (bus.wb_valid)
         sb_chk[bus.wb_rd] = 1'b0;
`endif
   end

   always_comb begin
      hazard = 1'b0;
      if (use1 && (f_rs1 != '0) && sb_chk[f_rs1])
         hazard = 1'b1;
      if (use2 && (f_rs2 != '0) && sb_chk[f_rs2])
         hazard = 1'b1;
      if (we && (f_rd != '0) && sb_chk[f_rd])
         hazard = 1'b1;
   end

   assign ready  = !bus.flush && !hazard &&
                   (!q.valid || bus.id_ready);
   assign accept = bus.if_valid && ready;

   // Set by a new issue must win over a same-cycle retire of that register.
   always_comb begin
      sb_n = sb;
      if (bus.wb_valid)
         sb_n[bus.wb_rd] = 1'b0;
      if (bus.flush && q.valid && !bus.id_ready && q.we)
         sb_n[q.rd] = 1'b0;
      if (accept && d.we && (d.rd != '0))
         sb_n[d.rd] = 1'b1;
      sb_n[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q  <= '0;
         sb <= '0;
      end else begin
         sb <= sb_n;
         if (accept)
            q <= d;
         else if (bus.flush || (q.valid && bus.id_ready))
            q.valid <= 1'b0;
      end
   end

   assign bus.if_ready   = ready;
   assign bus.id_valid   = q.valid;
   assign bus.id_opc     = q.opc;
   assign bus.id_rd      = q.rd;
   assign bus.id_rs1     = q.rs1;
   assign bus.id_rs2     = q.rs2;
   assign bus.id_imm     = q.imm;
   assign bus.id_use_imm = q.use_imm;
   assign bus.id_we      = q.we;
   assign bus.id_pc      = q.pc;
   assign bus.id_illegal = q.illegal;

endmodule

// File: tb/tb_instr_decode_issue.sv
// Directed + random bench for instr_decode_issue against a table-level model.
// Builds with or without WB_BYPASS_EN; expected issue timing follows the macro.
module tb_instr_decode_issue;

   logic clk;
   logic rst_n;

   instr_decode_issue_if #(.DATA_W(32), .REG_AW(5)) bus ();

   instr_decode_issue #(
      .DATA_W(32), .REG_AW(5), .NUM_REGS(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      bit        valid;
      bit [5:0]  opc;
      bit [4:0]  rd, rs1, rs2;
      bit [31:0] imm;
      bit        use_imm, we, illegal;
      bit [31:0] pc;
      bit        u1, u2;
   } mb_t;

   mb_t       m;
   bit [31:0] msb;
   int        n_cmp;
   int        n_bad;
   logic      obs_rdy;
   bit        last_acc;
   bit [31:0] pc_ctr;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decoding straight from the opcode table.
   function automatic mb_t mdec(bit [31:0] i, bit [31:0] pc);
      mb_t r;
      bit [5:0] o;
      r = '{default: '0};
      o = i[31:26];
      r.valid = 1'b1;
      r.opc = o;
      r.pc = pc;
      case (o)
         6'h00: ;
         6'h01, 6'h02, 6'h06, 6'h07, 6'h08, 6'h09,
         6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
            r.u1 = 1; r.u2 = 1; r.we = 1;
         end
         6'h05, 6'h0F: begin
            r.u1 = 1; r.we = 1;
         end
         6'h10: begin
            r.we = 1; r.use_imm = 1;
            r.imm = 32'($signed(i[15:0]));
         end
         6'h13, 6'h14, 6'h04: begin
            r.u1 = 1; r.we = 1; r.use_imm = 1;
            r.imm = 32'($signed(i[15:0]));
         end
         6'h11, 6'h12: begin
            r.u1 = 1; r.we = 1; r.use_imm = 1;
            r.imm = 32'(i[4:0]);
         end
         6'h03: begin
            r.u1 = 1; r.u2 = 1; r.use_imm = 1;
            r.imm = 32'($signed(i[15:0]));
         end
         6'h16: begin
            r.u1 = 1; r.use_imm = 1;
            r.imm = 32'($signed(i[15:0]));
         end
         6'h15: begin
            r.use_imm = 1;
            r.imm = 32'($signed(i[25:0]));
         end
         default: r.illegal = 1;
      endcase
      r.rd  = r.we ? i[25:21] : 5'd0;
      r.rs1 = r.u1 ? i[20:16] : 5'd0;
      r.rs2 = r.u2 ? i[15:11] : 5'd0;
      return r;
   endfunction

   function automatic bit mhaz(mb_t x);
      bit [31:0] s;
      s = msb;
      if (BYP && bus.wb_valid) s[bus.wb_rd] = 1'b0;
      return (x.u1 && x.rs1 != 0 && s[x.rs1]) ||
             (x.u2 && x.rs2 != 0 && s[x.rs2]) ||
             (x.we && x.rd != 0 && s[x.rd]);
   endfunction

   task automatic check_out();
      chk("id_valid", bus.id_valid, m.valid);
      chk("id_opc", bus.id_opc, m.opc);
      chk("id_rd", bus.id_rd, m.rd);
      chk("id_rs1", bus.id_rs1, m.rs1);
      chk("id_rs2", bus.id_rs2, m.rs2);
      chk("id_imm", bus.id_imm, m.imm);
      chk("id_use_imm", bus.id_use_imm, m.use_imm);
      chk("id_we", bus.id_we, m.we);
      chk("id_pc", bus.id_pc, m.pc);
      chk("id_illegal", bus.id_illegal, m.illegal);
   endtask

   // One clock: inputs are already set; check ready mid-cycle, advance model.
   task automatic step();
      mb_t x;
      bit  er, acc;
      bit [31:0] ns;
      @(negedge clk);
      x  = mdec(bus.if_instr, bus.if_pc);
      er = !bus.flush && !mhaz(x) && (!m.valid || bus.id_ready);
      obs_rdy = bus.if_ready;
      chk("if_ready", obs_rdy, er);
      acc = bus.if_valid && er;
      ns = msb;
      if (bus.wb_valid) ns[bus.wb_rd] = 1'b0;
      if (bus.flush && m.valid && !bus.id_ready && m.we)
         ns[m.rd] = 1'b0;
      if (acc && x.we && x.rd != 0) ns[x.rd] = 1'b1;
      ns[0] = 1'b0;
      if (acc) m = x;
      else if (bus.flush || (m.valid && bus.id_ready)) m.valid = 0;
      msb = ns;
      last_acc = acc;
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic offer(bit [31:0] instr);
      bus.if_valid = 1'b1;
      bus.if_instr = instr;
      pc_ctr += 4;
      bus.if_pc = pc_ctr;
   endtask

   task automatic drain();
      bus.if_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.id_ready = 1'b1;
      for (int r = 1; r < 32; r++) begin
         if (msb[r]) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = 5'(r);
            step();
         end
      end
      bus.wb_valid = 1'b0;
      step();
   endtask

   initial begin
      bit [31:0] held_pc;
      int lat;
      int pend[$];
      n_cmp = 0; n_bad = 0; pc_ctr = 32'h100;
      m = '{default: '0}; msb = '0;
      rst_n = 1'b0;
      bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0;
      bus.id_ready = 0; bus.wb_valid = 0; bus.wb_rd = 0;
      bus.flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_out();

      // ADD r3,r1,r2
      bus.id_ready = 1'b1;
      offer(32'h04611000);
      step();
      chk("add_opc", bus.id_opc, 6'h01);
      chk("add_rd", bus.id_rd, 5'd3);
      chk("add_rs2", bus.id_rs2, 5'd2);

      // ADDI r4,r3,-1 waits for r3 writeback
      offer(32'h4C83FFFF);
      repeat (3) begin
         step();
         chk("raw_stall", obs_rdy, 1'b0);
      end
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
      step();
      chk("wb_cycle_issue", obs_rdy, BYP);
      bus.wb_valid = 1'b0;
      lat = 0;
      for (int k = 0; k < 4 && !last_acc; k++) begin
         step();
         lat++;
      end
      chk("issue_lat", lat, BYP ? 0 : 1);
      chk("addi_imm", bus.id_imm, 32'hFFFFFFFF);
      chk("addi_use_imm", bus.id_use_imm, 1'b1);
      chk("addi_rs1", bus.id_rs1, 5'd3);

      // SLI r5,r0,31: r0 source never stalls
      offer(32'h44A0001F);
      step();
      chk("sli_rdy", obs_rdy, 1'b1);
      chk("sli_imm", bus.id_imm, 32'h1F);

      // Backpressure: MOVE r6,r1 blocked behind held SLI
      held_pc = bus.id_pc;
      bus.id_ready = 1'b0;
      offer(32'h14C10000);
      repeat (5) begin
         step();
         chk("bp_hold_pc", bus.id_pc, held_pc);
      end
      bus.id_ready = 1'b1;
      step();
      chk("bp_new_opc", bus.id_opc, 6'h05);
      bus.if_valid = 1'b0;
      step();
      chk("bp_no_dup", bus.id_valid, 1'b0);
      drain();

      // Flush a held, unconsumed ADD r3
      offer(32'h04611000);
      step();
      bus.if_valid = 1'b0; bus.id_ready = 1'b0;
      step();
      bus.flush = 1'b1;
      step();
      chk("flush_valid", bus.id_valid, 1'b0);
      bus.flush = 1'b0; bus.id_ready = 1'b1;
      offer(32'h05231800);
      step();
      chk("flush_sb_clear", obs_rdy, 1'b1);
      offer(32'hFFFFFFFF);
      step();
      chk("ill_flag", bus.id_illegal, 1'b1);
      chk("ill_we", bus.id_we, 1'b0);
      chk("ill_opc", bus.id_opc, 6'h3F);
      drain();

      // MOVEI r7 accepted while r7 retires
      offer(32'h40E01234);
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
      step();
      chk("movei_acc", obs_rdy, 1'b1);
      bus.wb_valid = 1'b0;
      offer(32'h05070000);
      step();
      chk("set_wins", obs_rdy, 1'b0);
      drain();

      // Async reset while stalled behind a held bundle
      offer(32'h14C10000);
      step();
      bus.id_ready = 1'b0;
      offer(32'h05231800);
      step();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.id_valid, 1'b0);
      chk("arst_pc", bus.id_pc, 32'h0);
      m = '{default: '0}; msb = '0;
      bus.if_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_out();

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         bit [5:0] o;
         o = ($urandom_range(0, 9) == 0) ?
             6'($urandom_range(6'h17, 6'h3F)) :
             6'($urandom_range(0, 6'h16));
         bus.if_valid = ($urandom_range(0, 3) != 0);
         bus.if_instr = {o, 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)),
                         11'($urandom)};
         bus.if_pc = $urandom;
         bus.id_ready = ($urandom_range(0, 9) < 7);
         bus.flush = ($urandom_range(0, 19) == 0);
         pend.delete();
         for (int r = 1; r < 32; r++)
            if (msb[r]) pend.push_back(r);
         bus.wb_valid = 1'b0;
         if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
         end else if ($urandom_range(0, 9) == 0) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd = 5'($urandom_range(0, 31));
         end
         step();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
